// File: rtl/pmu_event_counters.sv
// pmu_event_counters: N_CNT event counters with sticky overflow, write port and 1-cycle read port.
// Optional PMU_SNAPSHOT_EN adds a snapshot bank readable through rd_shadow_i.
module pmu_event_counters #(
    parameter int N_CNT = 24,
    parameter int CNT_W = 32,
    localparam int ADDR_W = $clog2(N_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_CNT-1:0]  events_i,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [CNT_W-1:0]  wr_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_shadow_i,
    input  logic              snap_i,
    output logic              rd_valid_o,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic [N_CNT-1:0]  overflow_o,
    input  logic [N_CNT-1:0]  ovf_clr_i
);
    logic [CNT_W-1:0] cnt [N_CNT];
    logic [N_CNT-1:0] hit, inc, wrap;
    logic [CNT_W-1:0] live_rd, rd_sel;

    // A write to a counter shadows its same-cycle event.
    always_comb begin
        hit = '0;
        inc = '0;
        wrap = '0;
        live_rd = '0;
        for (int x = 0; x < N_CNT; x++) begin
            hit[x] = wr_en_i && wr_addr_i == ADDR_W'(x);
            inc[x] = en_i && events_i[x] && !hit[x];
            wrap[x] = inc[x] && &cnt[x];
            if (rd_addr_i == ADDR_W'(x)) live_rd = cnt[x];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int x = 0; x < N_CNT; x++) begin
            if (rst_i || clr_i) cnt[x] <= '0;
            else if (hit[x]) cnt[x] <= wr_data_i;
            else if (inc[x]) cnt[x] <= cnt[x] + CNT_W'(1);
        end
        overflow_o <= (rst_i || clr_i) ? '0 : wrap | (overflow_o & ~ovf_clr_i);
    end

`ifdef PMU_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow [N_CNT];
    logic [CNT_W-1:0] shadow_rd;

    always_comb begin
        shadow_rd = '0;
        for (int x = 0; x < N_CNT; x++)
            if (rd_addr_i == ADDR_W'(x)) shadow_rd = shadow[x];
    end

    always_ff @(posedge clk_i) begin
        for (int x = 0; x < N_CNT; x++) begin
            if (rst_i) shadow[x] <= '0;
            else if (snap_i) shadow[x] <= cnt[x];
        end
    end

    assign rd_sel = rd_shadow_i ? shadow_rd : live_rd;
`else
    logic unused_snap;
    assign unused_snap = snap_i ^ rd_shadow_i;
    assign rd_sel = live_rd;
`endif

    // Out-of-range addresses match no entry, so they read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_valid_o <= rd_req_i;
            if (rd_req_i) rd_data_o <= rd_sel;
        end
    end
endmodule

// File: tb/tb_pmu_event_counters.sv
// tb_pmu_event_counters: directed + randomized checks of pmu_event_counters against an array model.
module tb_pmu_event_counters;
    localparam int N = 24;
    localparam int W = 32;
`ifdef PMU_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i, en_i, clr_i, wr_en_i, rd_req_i, rd_shadow_i, snap_i;
    logic [N-1:0] events_i, ovf_clr_i;
    logic [4:0]   wr_addr_i, rd_addr_i;
    logic [W-1:0] wr_data_i;
    logic         rd_valid_o;
    logic [W-1:0] rd_data_o;
    logic [N-1:0] overflow_o;

    pmu_event_counters dut (
        .clk_i(clk), .rst_i(rst_i), .events_i(events_i), .en_i(en_i), .clr_i(clr_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_shadow_i(rd_shadow_i), .snap_i(snap_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .overflow_o(overflow_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [W-1:0] m_cnt [N];
    logic [W-1:0] m_sh [N];
    logic [N-1:0] m_ovf;
    logic         m_valid;
    logic [W-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge of the spec rules to the model, using the inputs now on the pins.
    task automatic model_step();
        logic [W:0] nx;
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = '0;
                m_sh[i] = '0;
            end
            m_ovf = '0;
            m_valid = 1'b0;
            m_data = '0;
        end else begin
            m_valid = rd_req_i;
            if (rd_req_i)
                m_data = (rd_addr_i >= N) ? '0 : (SNAP && rd_shadow_i) ? m_sh[rd_addr_i] : m_cnt[rd_addr_i];
            if (SNAP && snap_i)
                for (int i = 0; i < N; i++) m_sh[i] = m_cnt[i];
            if (clr_i) begin
                for (int i = 0; i < N; i++) m_cnt[i] = '0;
                m_ovf = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    m_ovf[i] = m_ovf[i] & ~ovf_clr_i[i];
                    if (wr_en_i && wr_addr_i == i) m_cnt[i] = wr_data_i;
                    else if (en_i && events_i[i]) begin
                        nx = {1'b0, m_cnt[i]} + 1;
                        m_cnt[i] = nx[W-1:0];
                        if (nx[W]) m_ovf[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("rd_valid", rd_valid_o, m_valid);
        chk("rd_data", rd_data_o, m_data);
        chk("overflow", overflow_o, m_ovf);
    endtask

    task automatic idle();
        rst_i = 0; en_i = 0; clr_i = 0; wr_en_i = 0; rd_req_i = 0; rd_shadow_i = 0; snap_i = 0;
        events_i = '0; ovf_clr_i = '0; wr_addr_i = '0; rd_addr_i = '0; wr_data_i = '0;
    endtask

    task automatic rd(input int a, input bit sh);
        rd_req_i = 1; rd_addr_i = 5'(a); rd_shadow_i = sh;
        tick();
        rd_req_i = 0; rd_shadow_i = 0;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en_i = 1; wr_addr_i = 5'(a); wr_data_i = d;
        tick();
        wr_en_i = 0;
    endtask

    initial begin
        idle();
        @(negedge clk);
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
        // 1: ten events on counter 3
        en_i = 1; events_i = N'(1) << 3;
        repeat (10) tick();
        events_i = '0;
        rd(3, 0);
        chk("t1_cnt3", rd_data_o, 10);
        tick();
        chk("t1_valid_drop", rd_valid_o, 0);
        for (int i = 0; i < N; i++) rd(i, 0);
        // 2: wrap and overflow clear
        wr(5, 32'hFFFF_FFFE);
        events_i = N'(1) << 5;
        repeat (2) tick();
        events_i = '0;
        chk("t2_ovf5", overflow_o[5], 1);
        rd(5, 0);
        chk("t2_cnt5", rd_data_o, 0);
        ovf_clr_i = N'(1) << 5;
        tick();
        ovf_clr_i = '0;
        chk("t2_ovf5_clr", overflow_o[5], 0);
        // 3: write + event + read same cycle
        events_i = N'(1) << 7;
        repeat (4) tick();
        wr_en_i = 1; wr_addr_i = 7; wr_data_i = 100;
        rd(7, 0);
        wr_en_i = 0; events_i = '0;
        chk("t3_old", rd_data_o, 4);
        rd(7, 0);
        chk("t3_new", rd_data_o, 100);
        // 4: disabled counting, then clear with events
        en_i = 0; events_i = '1;
        repeat (5) tick();
        rd(3, 0);
        chk("t4_hold3", rd_data_o, 10);
        en_i = 1; clr_i = 1;
        tick();
        clr_i = 0; events_i = '0;
        chk("t4_ovf", overflow_o, 0);
        for (int i = 0; i < N; i++) rd(i, 0);
        // 5: out-of-range read and write
        wr_en_i = 1; wr_addr_i = 31; wr_data_i = 32'hDEAD_BEEF;
        rd(24, 0);
        wr_en_i = 0;
        chk("t5_valid", rd_valid_o, 1);
        chk("t5_data", rd_data_o, 0);
        for (int i = 0; i < N; i++) rd(i, 0);
        // 6: snapshot
        events_i = 1;
        repeat (8) tick();
        events_i = '0; snap_i = 1;
        tick();
        snap_i = 0; events_i = 1;
        repeat (4) tick();
        events_i = '0;
        rd(0, 1);
        chk("t6_shadow", rd_data_o, SNAP ? 8 : 12);
        rd(0, 0);
        chk("t6_live", rd_data_o, 12);
        // reset coinciding with a read request
        rd_req_i = 1; rd_addr_i = 0; rst_i = 1;
        tick();
        idle();
        chk("rst_read_valid", rd_valid_o, 0);
        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            clr_i = ($urandom_range(0, 63) == 0);
            en_i = ($urandom_range(0, 3) != 0);
            events_i = N'($urandom);
            ovf_clr_i = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            wr_en_i = ($urandom_range(0, 3) == 0);
            wr_addr_i = 5'($urandom_range(0, 31));
            wr_data_i = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            rd_req_i = ($urandom_range(0, 2) != 0);
            rd_addr_i = 5'($urandom_range(0, 31));
            rd_shadow_i = $urandom_range(0, 1) == 1;
            snap_i = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/pmu_event_counters.md
Name: pmu_event_counters

Overview:
Consumer end of the PMU event routing path. Takes the registered per-counter event strobes produced by the event crossbar and accumulates them in N_CNT independent counters. Sets sticky overflow flags on wrap. Exposes a single-cycle register write port and a one-cycle-latency read port to the PMU register file.

Parameters:
N_CNT, 24, number of counters; equals the crossbar output count.
CNT_W, 32, counter width in bits.
ADDR_W, $clog2(N_CNT), counter index width; localparam.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
events_i  in  N_CNT  event strobes; bit x is crossbar output x
en_i  in  1  global count enable
clr_i  in  1  global clear of counters and overflow flags
wr_en_i  in  1  counter write strobe
wr_addr_i  in  ADDR_W  counter index to write
wr_data_i  in  CNT_W  value to load
rd_req_i  in  1  read request
rd_addr_i  in  ADDR_W  counter index to read
rd_shadow_i  in  1  read from snapshot bank instead of live counters (see Optional Feature)
snap_i  in  1  capture all live counters into snapshot bank (see Optional Feature)
rd_valid_o  out  1  read data valid, one-cycle pulse
rd_data_o  out  CNT_W  read data
overflow_o  out  N_CNT  sticky per-counter overflow flags
ovf_clr_i  in  N_CNT  per-counter overflow flag clear

Behaviour:
- Reset (rst_i=1 at a clk_i edge) sets all counters, overflow_o, rd_valid_o, rd_data_o and the snapshot bank to 0. Reset overrides every other input, including mid-read: a read whose request edge coincides with reset produces no rd_valid_o.
- Per-counter update priority, highest first: rst_i > clr_i > write to this index > increment.
- Increment: if en_i=1 and events_i[x]=1, cnt[x] <= cnt[x]+1 modulo 2^CNT_W.
- Wrap from all-ones to 0 sets overflow_o[x]=1 on the same edge.
- Write: when wr_en_i=1 and wr_addr_i<N_CNT, cnt[wr_addr_i] <= wr_data_i. An event on that counter in the same cycle is dropped.
- A write never sets or clears the overflow flag. A write with wr_addr_i>=N_CNT is ignored.
- clr_i=1: all counters and all overflow flags go to 0. Events and writes in that cycle are dropped.
- Overflow flags: ovf_clr_i[x]=1 clears bit x. If a wrap and ovf_clr_i[x] occur in the same cycle, the wrap wins and the flag stays 1.
- Read: rd_req_i=1 at edge N gives rd_valid_o=1 for exactly one cycle after edge N. rd_data_o is the counter value before edge N's update, i.e. any same-cycle increment or write is not visible.
- rd_addr_i>=N_CNT returns rd_data_o=0 with rd_valid_o=1.
- Back-to-back reads are allowed, one per cycle, with rd_valid_o held high. When rd_valid_o=0, rd_data_o holds its last value.
- No backpressure. Reads and writes are accepted every cycle, independently.

Optional Feature:
Macro PMU_SNAPSHOT_EN.
- Defined: the block contains a shadow bank of N_CNT x CNT_W registers.
  - snap_i=1 copies every counter's pre-update value into the bank on that edge.
  - A read with rd_shadow_i=1 returns shadow[rd_addr_i] under the same latency and range rules as a live read.
  - snap_i and a shadow read in the same cycle return the old shadow value.
  - clr_i does not clear the shadow bank; only rst_i does.
- Not defined: no shadow storage is built. snap_i and rd_shadow_i are ignored, and all reads return live counters.
- Ports are identical in both builds.

Test Plan:
1. Reset, then en_i=1, events_i[3]=1 for 10 cycles, then read addr 3 -> rd_valid_o pulses one cycle after the request with rd_data_o=10; all other counters read 0.
2. Write cnt[5]=32'hFFFF_FFFE, then hold events_i[5]=1 for 2 cycles -> cnt[5]=0 and overflow_o[5]=1. Next, ovf_clr_i[5]=1 for one cycle -> overflow_o[5]=0.
3. Same cycle: wr_en_i to index 7 with data 100, events_i[7]=1, rd_req_i addr 7 (old value 4) -> rd_data_o=4, and a read the following cycle returns 100.
4. Set en_i=0 with all events_i high for 5 cycles -> all counters unchanged. Then assert clr_i together with events -> all counters 0 and overflow_o=0.
5. Read rd_addr_i=N_CNT (24), and write wr_addr_i=31 -> rd_valid_o=1 with rd_data_o=0; no counter changes.
6. With PMU_SNAPSHOT_EN: count 8 events on cnt[0], pulse snap_i, count 4 more, read with rd_shadow_i=1 -> rd_data_o=8; read with rd_shadow_i=0 -> rd_data_o=12. Without the macro both reads return 12.
